// File: rtl/contador_pkg.sv
// contador_pkg: shared types and reset defaults for the bouncing-counter
// sequencer.
//   mode_t  : traversal mode as carried on cfg_mode (RSVD behaves as BOUNCE)
//   state_t : sequencer FSM states
//   DEF_*   : reset values of the registered run configuration
//   to_mode : maps a raw 2-bit cfg_mode to the mode that is actually run
package contador_pkg;

  typedef enum logic [1:0] {
    BOUNCE    = 2'd0,
    UP_WRAP   = 2'd1,
    DOWN_WRAP = 2'd2,
    RSVD      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Reset configuration spans the full counter range in BOUNCE mode with an
  // unlimited pass count, reproducing the free-running 0..max..0 bounce.
  // The limits are width-dependent, so they are given as fill bits.
  localparam logic  DEF_LOW_FILL  = 1'b0;
  localparam logic  DEF_HIGH_FILL = 1'b1;
  localparam mode_t DEF_MODE      = BOUNCE;
  localparam int    DEF_PASSES    = 0;

  // Reserved encoding is stored as BOUNCE so the FSM never has to see it.
  function automatic mode_t to_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd1:    m = UP_WRAP;
      2'd2:    m = DOWN_WRAP;
      default: m = BOUNCE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/contador_datapath.sv
// contador_datapath: W-bit counter register with load and up/down step, plus
// compare flags against the programmed limits.
//   clock, reset      : rising-edge clock, async active-high reset (value=0)
//   load, load_val    : load has priority over counting
//   en, dir           : step by one when en; dir=0 up, dir=1 down (mod 2^W)
//   low, high         : limits used only for the compare outputs
//   value             : current count
//   at_low, at_high   : value equals low / high
module contador_datapath #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  input  logic [W-1:0] low,
  input  logic [W-1:0] high,
  output logic [W-1:0] value,
  output logic         at_low,
  output logic         at_high
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= dir ? value - W'(1) : value + W'(1);
    end
  end

  assign at_low  = (value == low);
  assign at_high = (value == high);

endmodule

// File: rtl/contador_seq_ctrl.sv
// contador_seq_ctrl: sequencer/configurator for the up/down bouncing counter.
// A configuration (limits, mode, pass count) is accepted over cfg_valid/
// cfg_ready while IDLE; start runs the counter between the limits, stop
// aborts, and done pulses when the programmed number of passes completes.
//   clock, reset               : rising-edge clock, async active-high reset
//   cfg_valid/cfg_ready        : config handshake (ready only in IDLE)
//   cfg_low/high/mode/passes   : offered configuration
//   cfg_err                    : one-cycle pulse after a config with low>high
//   start, stop                : run control
//   busy, done                 : running / run-complete pulse
//   saida, dir, pass_cnt       : counter value, direction, passes completed
// Optional build macro CONTADOR_PAUSE_EN adds input pause, which freezes a
// running sequence (stop still aborts). Default build has no pause port.
module contador_seq_ctrl
  import contador_pkg::*;
#(
  parameter int W      = 4,
  parameter int PASS_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W-1:0]      cfg_low,
  input  logic [W-1:0]      cfg_high,
  input  logic [1:0]        cfg_mode,
  input  logic [PASS_W-1:0] cfg_passes,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      saida,
  output logic              dir,
  output logic [PASS_W-1:0] pass_cnt
`ifdef CONTADOR_PAUSE_EN
  ,
  input  logic              pause
`endif
);

  state_t              state, state_nxt;
  logic                dir_nxt;
  logic [PASS_W-1:0]   pass_nxt;
  logic                done_nxt;

  logic [W-1:0]        low_r, high_r;
  mode_t               mode_r;
  logic [PASS_W-1:0]   passes_r;

  logic                cfg_fire, cfg_bad, cfg_ok, start_go, frozen;
  logic [W-1:0]        eff_low, eff_high;
  mode_t               eff_mode;

  logic                dp_load, dp_en, dp_dir;
  logic [W-1:0]        dp_load_val;
  logic                at_low, at_high, endpoint;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_bad   = cfg_fire && (cfg_low > cfg_high);
  assign cfg_ok    = cfg_fire && !cfg_bad;
  // A rejected config also suppresses a start offered at the same edge.
  assign start_go  = start && (state == IDLE) && !cfg_bad;

  // A start accepted together with a good config runs the incoming values.
  assign eff_low   = cfg_ok ? cfg_low          : low_r;
  assign eff_high  = cfg_ok ? cfg_high         : high_r;
  assign eff_mode  = cfg_ok ? to_mode(cfg_mode) : mode_r;

`ifdef CONTADOR_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  contador_datapath #(.W(W)) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     (dp_load),
    .load_val (dp_load_val),
    .en       (dp_en),
    .dir      (dp_dir),
    .low      (low_r),
    .high     (high_r),
    .value    (saida),
    .at_low   (at_low),
    .at_high  (at_high)
  );

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    pass_nxt    = pass_cnt;
    done_nxt    = 1'b0;
    dp_load     = 1'b0;
    dp_load_val = eff_low;
    dp_en       = 1'b0;
    dp_dir      = (state == DOWN);
    endpoint    = (state == UP) ? at_high : at_low;

    case (state)
      IDLE: begin
        if (start_go) begin
          pass_nxt = '0;
          dp_load  = 1'b1;
          if (eff_mode == DOWN_WRAP) begin
            state_nxt   = DOWN;
            dir_nxt     = 1'b1;
            dp_load_val = eff_high;
          end else begin
            state_nxt   = UP;
            dir_nxt     = 1'b0;
            dp_load_val = eff_low;
          end
        end
      end

      UP, DOWN: begin
        // stop takes priority over both pause and a pass completion.
        if (stop) begin
          state_nxt = IDLE;
        end else if (!frozen) begin
          if (!endpoint) begin
            dp_en = 1'b1;
          end else begin
            if (state == UP && mode_r == UP_WRAP) begin
              dp_load     = 1'b1;
              dp_load_val = low_r;
            end else if (state == DOWN && mode_r == DOWN_WRAP) begin
              dp_load     = 1'b1;
              dp_load_val = high_r;
            end else begin
              // Bounce: value dwells one cycle at the limit, direction flips.
              dir_nxt   = (state == UP);
              state_nxt = (state == UP) ? DOWN : UP;
            end
            pass_nxt = (pass_cnt == '1) ? pass_cnt : pass_cnt + PASS_W'(1);
            if (passes_r != '0 && pass_nxt == passes_r) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the configuration registers are reset along with the FSM so a
  // reset mid-run always restores the full-range free-running bounce.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      pass_cnt <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      low_r    <= {W{DEF_LOW_FILL}};
      high_r   <= {W{DEF_HIGH_FILL}};
      mode_r   <= DEF_MODE;
      passes_r <= PASS_W'(DEF_PASSES);
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      pass_cnt <= pass_nxt;
      done     <= done_nxt;
      cfg_err  <= cfg_bad;
      if (cfg_ok) begin
        low_r    <= cfg_low;
        high_r   <= cfg_high;
        mode_r   <= to_mode(cfg_mode);
        passes_r <= cfg_passes;
      end
    end
  end

endmodule
